// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder controller.
// Sends operand bits LSB first to an external 1-bit full_adder, keeps the
// carry in a register between bits, and collects the sum bits into a result.
// A start/busy/done handshake frames each addition. One addition takes WIDTH
// cycles in ADD, followed by a single DONE cycle. A start seen in ADD or DONE
// is ignored, so the earliest next accepting edge is the edge after the one
// that ends the done pulse.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_add;

  // Bit path to the full_adder is live only in ADD; it idles at zero otherwise.
  assign in_add = (state_q == S_ADD);
  assign fa_a   = in_add & a_sh_q[0];
  assign fa_b   = in_add & b_sh_q[0];
  assign fa_cin = in_add & carry_q;

  // Status is decoded straight from the state register (Moore outputs).
  assign busy = in_add;
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

  // Next-state and datapath update for the IDLE -> ADD -> DONE sequence.
  always_comb begin
    // NOTE: every signal gets a hold default first, so no path can infer a latch.
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
        carry_d = fa_carry;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        // Publish the result only once, on the final bit, so sum/cout never
        // show a partially built value.
        if (cnt_q == LAST_BIT) begin
          sum_d   = {fa_sum, acc_q[WIDTH-1:1]};
          cout_d  = fa_carry;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset that clears everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
